// File: rtl/dl_bitwise_pkg.sv
// Shared types for the bitwise reduction blocks: fold operations and the
// packet accumulator state encoding.
package dl_bitwise_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_PASS = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ACCUM = 2'b01,
      S_HOLD  = 2'b10
   } state_e;

endpackage

// File: rtl/dl_bitwise_op.sv
// Combinational lane-wise fold y = f(a, b, op). PASS returns the newer
// operand b, so a running fold under PASS keeps the most recent beat.
module dl_bitwise_op
   import dl_bitwise_pkg::*;
#(
   parameter int NUM_BITS = 32
) (
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  op_e                 op,
   output logic [NUM_BITS-1:0] y
);

   // select the lane-wise operation
   always_comb begin
      y = a & b;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_PASS: y = b;
         default: y = a & b;
      endcase
   end

endmodule

// File: rtl/dl_bitwise_accum.sv
// Stream bitwise reduction engine: folds the beats of a packet with the op
// captured on its first beat and holds one registered result per packet.
// A packet ends on in_last or when MAX_BEATS beats have been folded; any
// beats beyond that start a fresh packet.
module dl_bitwise_accum
   import dl_bitwise_pkg::*;
#(
   parameter int NUM_BITS  = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_BITS-1:0]            in_data,
   input  logic [1:0]                     in_op,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_BITS-1:0]            out_data,
   output logic [$clog2(MAX_BEATS+1)-1:0] out_count,
   output logic                           out_trunc
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

   state_e              state;
   op_e                 op_q;
   logic [NUM_BITS-1:0] acc;
   logic [CW-1:0]       count;
   logic                trunc;

   logic                take;
   logic                first;
   logic                term;
   logic [CW-1:0]       count_next;
   logic [NUM_BITS-1:0] acc_next;
   logic [NUM_BITS-1:0] fold_y;

   dl_bitwise_op #(.NUM_BITS(NUM_BITS)) u_op (
      .a  (acc),
      .b  (in_data),
      .op (op_q),
      .y  (fold_y)
   );

   // HOLD blocks input unless the result is drained in the same cycle,
   // which keeps packets back-to-back without a bubble
   assign in_ready  = (state != S_HOLD) || out_ready;
   assign out_valid = (state == S_HOLD);
   assign out_data  = acc;
   assign out_count = count;
   assign out_trunc = trunc;

   // next-beat values: a first beat loads directly, later beats fold
   always_comb begin
      take       = in_valid && in_ready;
      first      = (state != S_ACCUM);
      count_next = first ? CW'(1) : count + CW'(1);
      acc_next   = first ? in_data : fold_y;
      term       = in_last || (count_next == MAX_CNT);
   end

   // packet FSM with accumulator, count, op and truncation registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         op_q  <= OP_AND;
         acc   <= '0;
         count <= '0;
         trunc <= 1'b0;
      end else if (take) begin
         acc   <= acc_next;
         count <= count_next;
         if (first) begin
            op_q <= op_e'(in_op);
         end
         if (term) begin
            state <= S_HOLD;
            trunc <= !in_last;
         end else begin
            state <= S_ACCUM;
         end
      end else if ((state == S_HOLD) && out_ready) begin
         state <= S_IDLE;
      end
   end

endmodule

// File: doc/dl_bitwise_accum.md
# dl_bitwise_accum

Parametrised, stream-oriented bitwise reduction engine. Accepts a packet of NUM_BITS-wide beats over a valid/ready handshake, folds the beats lane-by-lane with a selectable operation (AND, OR, XOR, PASS), and presents one registered result per packet on a valid/ready output. It is the sequential, multi-op successor to the library's single-cycle bitwise gates, used for mask merging, parity/checksum folding and flag aggregation.

## Interface
- NUM_BITS, 32, lane width of data and result
- MAX_BEATS, 16, maximum beats per packet (≥1); longer packets are truncated
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  NUM_BITS  beat data
- in_op  input  2  dl_bitwise_pkg::op_e; sampled on first beat of packet only
- in_last  input  1  final beat of packet
- out_valid  output  1  result held
- out_ready  input  1  result consumed when out_valid && out_ready
- out_data  output  NUM_BITS  reduced result
- out_count  output  $clog2(MAX_BEATS+1)  beats folded into out_data (1..MAX_BEATS)
- out_trunc  output  1  packet hit MAX_BEATS without in_last

## Operation
- States: IDLE (no packet open), ACCUM (packet open, ≥1 beat folded), HOLD (result valid).
- Ops: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_PASS=2'b11 (result = most recent beat).
- First beat (IDLE, or HOLD with out_ready): acc ← in_data, op_q ← in_op, count ← 1. Identity of every op makes this equal to folding with the identity.
- Subsequent beat (ACCUM): acc ← f(acc, in_data, op_q), count ← count+1; in_op ignored.
- Accepted beat with in_last, or beat bringing count to MAX_BEATS → HOLD; out_trunc ← (!in_last at that beat). Else → ACCUM.
- After truncation, following beats of the over-long packet are treated as a new packet; no beats are dropped.
- HOLD with out_ready and no accepted beat → IDLE.
- in_ready = (state != HOLD) || out_ready. Bubble-free: output handshake and a new first beat in the same cycle load the new beat and move to ACCUM (or HOLD if that beat has in_last / MAX_BEATS==1).
- out_data, out_count, out_trunc are stable while out_valid && !out_ready.
- in_valid may be deasserted mid-packet; state and acc hold.
- Reset (any time, including mid-packet or in HOLD): state IDLE, acc 0, count 0, op_q OP_AND, out_valid 0, out_data 0, out_count 0, out_trunc 0; partial packet discarded.

## Timing
- Latency: out_valid rises the cycle after the terminating beat is accepted; out_data is a flop output.
- Throughput: one beat per cycle sustained, including across packet boundaries, provided out_ready is high when HOLD is entered.
- in_ready is combinational only from out_ready and state; no in_valid→in_ready path.
- Single-beat packet: accepted at cycle N, out_valid at N+1.

## Structure
- dl_bitwise_pkg: op_e enum (OP_AND, OP_OR, OP_XOR, OP_PASS), state_e enum (S_IDLE, S_ACCUM, S_HOLD).
- Sub-module dl_bitwise_op #(NUM_BITS): combinational f(a, b, op) → y; reused by other library blocks.
- Top: FSM, acc/count/op_q/trunc registers, handshake logic.

## Test plan
- NUM_BITS=8: OP_AND beats 0xF0, 0x3C, 0xFF(last) → out_data 0x30, out_count 3, out_trunc 0, out_valid one cycle after last.
- OP_XOR single beat 0xA5 with in_last → out_data 0xA5, out_count 1; then OP_OR 0x01, 0x80(last) issued with out_ready high → second result 0x81 with no idle cycle between packets.
- MAX_BEATS=4, OP_OR beats 0x01,0x02,0x04,0x08,0x10(last) → result 0x0F count 4 trunc 1, then 0x10 count 1 trunc 0.
- out_ready held low 5 cycles in HOLD → in_ready 0, out_data/out_count stable; release → handshake, next beat accepted same cycle.
- Op change mid-packet: OP_AND first beat 0xFF, then in_op=OP_OR with 0x0F(last) → 0x0F under AND (op ignored after first beat); OP_PASS 0x11,0x22(last) → 0x22.
- rst_n asserted asynchronously mid-ACCUM and in HOLD → all outputs 0 immediately; next packet after release reduces from scratch with correct result.
